// File: rtl/gray_seq_pkg.sv
// rtl/gray_seq_pkg.sv - shared state type, default width and bin-to-Gray helper for gray_seq_ctrl
package gray_seq_pkg;

  localparam int GRAY_SEQ_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gray_seq_state_t;

  // Operates on a 32-bit container; callers truncate to their own width.
  function automatic logic [31:0] bin_to_gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/bin2gray.sv
// rtl/bin2gray.sv - combinational binary to Gray code converter
module bin2gray
  import gray_seq_pkg::*;
#(
  parameter int W = GRAY_SEQ_W_DEF
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  assign gray = W'(bin_to_gray(32'(bin)));

endmodule

// File: rtl/gray_seq_ctrl.sv
// rtl/gray_seq_ctrl.sv - Gray code sequence generator with valid/ready output handshake
// Optional binary mirror output enabled by GRAY_SEQ_BIN_OUT_EN.
module gray_seq_ctrl
  import gray_seq_pkg::*;
#(
  parameter int W = GRAY_SEQ_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic         dir,
  input  logic         cont,
  input  logic [W-1:0] limit,
  input  logic         out_ready,
  output logic [W-1:0] gray,
  output logic         out_valid,
  output logic         busy,
  output logic         done
`ifdef GRAY_SEQ_BIN_OUT_EN
  ,
  output logic [W-1:0] bin
`endif
);

  gray_seq_state_t state, state_nxt;

  logic [W-1:0] cnt, cnt_nxt;
  logic [W-1:0] limit_q, limit_nxt;
  logic [W-1:0] gray_nxt;
  logic [W-1:0] reload_val;
  logic         dir_q, dir_nxt;
  logic         cont_q, cont_nxt;
  logic         valid_nxt;
  logic         done_nxt;
  logic         beat;
  logic         last_beat;

  assign beat       = out_valid & out_ready;
  assign last_beat  = dir_q ? (cnt == limit_q) : (cnt == '0);
  assign reload_val = dir_q ? '0 : limit_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dir_nxt   = dir_q;
    cont_nxt  = cont_q;
    limit_nxt = limit_q;
    done_nxt  = 1'b0;

    case (state)
      IDLE, DONE: begin
        // stop dominates a simultaneous start
        if (start && !stop) begin
          dir_nxt   = dir;
          cont_nxt  = cont;
          limit_nxt = limit;
          cnt_nxt   = dir ? '0 : limit;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end

      RUN: begin
        if (beat) begin
          if (last_beat) begin
            if (cont_q) begin
              cnt_nxt = reload_val;
            end
          end else begin
            cnt_nxt = dir_q ? (cnt + W'(1)) : (cnt - W'(1));
          end
        end

        if (stop) begin
          state_nxt = IDLE;
        end else if (beat && last_beat && !cont_q) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase

    valid_nxt = (state_nxt == RUN);
  end

  bin2gray #(
    .W(W)
  ) u_bin2gray (
    .bin (cnt_nxt),
    .gray(gray_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      gray      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dir_q     <= 1'b1;
      cont_q    <= 1'b0;
      limit_q   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      gray      <= gray_nxt;
      out_valid <= valid_nxt;
      busy      <= valid_nxt;
      done      <= done_nxt;
      dir_q     <= dir_nxt;
      cont_q    <= cont_nxt;
      limit_q   <= limit_nxt;
    end
  end

`ifdef GRAY_SEQ_BIN_OUT_EN
  // Loaded from the same next-count as gray so the two stay cycle-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin <= '0;
    end else begin
      bin <= cnt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb/tb_gray_seq_ctrl.sv - self-checking bench for gray_seq_ctrl (W=4)
module tb_gray_seq_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         stop;
  logic         dir;
  logic         cont;
  logic [W-1:0] limit;
  logic         out_ready;
  logic [W-1:0] gray;
  logic         out_valid;
  logic         busy;
  logic         done;
`ifdef GRAY_SEQ_BIN_OUT_EN
  logic [W-1:0] bin;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string        name;
    logic         start;
    logic         stop;
    logic         dir;
    logic         cont;
    logic [W-1:0] limit;
    logic         ready;
    logic         chk_gray;
    logic [W-1:0] gray;
    logic         valid;
    logic         busy;
    logic         done;
  } vec_t;

  vec_t vecs[$];

  logic [W-1:0] gray_tbl [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                  4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  always #5 clk = ~clk;

  gray_seq_ctrl #(
    .W(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .dir      (dir),
    .cont     (cont),
    .limit    (limit),
    .out_ready(out_ready),
    .gray     (gray),
    .out_valid(out_valid),
    .busy     (busy),
    .done     (done)
`ifdef GRAY_SEQ_BIN_OUT_EN
    ,
    .bin      (bin)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic st, input logic sp, input logic d,
                     input logic c, input logic [W-1:0] lim, input logic rdy, input logic cg,
                     input logic [W-1:0] g, input logic v, input logic b, input logic dn);
    vec_t t;
    t.name = name; t.start = st; t.stop = sp; t.dir = d; t.cont = c; t.limit = lim;
    t.ready = rdy; t.chk_gray = cg; t.gray = g; t.valid = v; t.busy = b; t.done = dn;
    vecs.push_back(t);
  endtask

  task automatic add_run(input string name, input logic [W-1:0] g);
    add(name, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, g, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic add_done(input string name);
    add(name, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic add_idle(input string name);
    add(name, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b0; cont = 1'b0;
    limit = '0; out_ready = 1'b1;

    // up, limit 5
    add("up5", 1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
    add_run("up5", 4'd1); add_run("up5", 4'd3); add_run("up5", 4'd2);
    add_run("up5", 4'd6); add_run("up5", 4'd7);
    add_done("up5_done"); add_idle("up5_idle");
    // down, limit 3
    add("dn3", 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0);
    add_run("dn3", 4'd3); add_run("dn3", 4'd1); add_run("dn3", 4'd0);
    add_done("dn3_done"); add_idle("dn3_idle");
    // backpressure, then ignored start/config in RUN, then stop
    add("bp7", 1'b1, 1'b0, 1'b1, 1'b0, 4'd7, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
    add_run("bp7", 4'd1); add_run("bp7", 4'd3);
    for (int k = 0; k < 3; k++)
      add("bp7_hold", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
    add_run("bp7_rel", 4'd2);
    add("bp7_ign", 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0);
    add("bp7_stop", 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    add_idle("bp7_idle");
    // continuous, limit 1, stop after cycle 6
    add("cont1", 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
    add_run("cont1", 4'd1); add_run("cont1", 4'd0); add_run("cont1", 4'd1);
    add_run("cont1", 4'd0); add_run("cont1", 4'd1);
    add("cont1_stop", 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    add_idle("cont1_idle");
    // start and stop together in IDLE
    add("ss", 1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    add_idle("ss_idle");
    // limit 0 up, restart straight out of DONE
    add("lim0", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
    add("lim0_done", 1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    add("restart", 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
    add_run("restart", 4'd1);
    add_done("restart_done"); add_idle("restart_idle");
    // limit 0 down
    add("dn0", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
    add_done("dn0_done"); add_idle("dn0_idle");

    step(); step();
    chk("rst_gray", 32'(gray), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
`ifdef GRAY_SEQ_BIN_OUT_EN
    chk("rst_bin", 32'(bin), 32'd0);
`endif
    rst_n = 1'b1;
    step();
    chk("idle_valid", 32'(out_valid), 32'd0);

    foreach (vecs[i]) begin
      start = vecs[i].start; stop = vecs[i].stop; dir = vecs[i].dir;
      cont = vecs[i].cont; limit = vecs[i].limit; out_ready = vecs[i].ready;
      step();
      chk($sformatf("%s[%0d].valid", vecs[i].name, i), 32'(out_valid), 32'(vecs[i].valid));
      chk($sformatf("%s[%0d].busy", vecs[i].name, i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("%s[%0d].done", vecs[i].name, i), 32'(done), 32'(vecs[i].done));
      if (vecs[i].chk_gray)
        chk($sformatf("%s[%0d].gray", vecs[i].name, i), 32'(gray), 32'(vecs[i].gray));
    end
    start = 1'b0; stop = 1'b0; out_ready = 1'b1;

    // full-range up count, limit 15
    start = 1'b1; dir = 1'b1; cont = 1'b0; limit = 4'd15;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("full[%0d].gray", i), 32'(gray), 32'(gray_tbl[i]));
      chk($sformatf("full[%0d].valid", i), 32'(out_valid), 32'd1);
`ifdef GRAY_SEQ_BIN_OUT_EN
      chk($sformatf("full[%0d].bin", i), 32'(bin), 32'(i));
`endif
      step();
    end
    chk("full_done", 32'(done), 32'd1);
    chk("full_end_valid", 32'(out_valid), 32'd0);
    step();
    chk("full_done_clr", 32'(done), 32'd0);

    // asynchronous reset while gray=6
    start = 1'b1; dir = 1'b1; limit = 4'd15;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("arst_pre_gray", 32'(gray), 32'd6);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gray", 32'(gray), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
`ifdef GRAY_SEQ_BIN_OUT_EN
    chk("arst_bin", 32'(bin), 32'd0);
`endif
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst[%0d].valid", i), 32'(out_valid), 32'd0);
      chk($sformatf("post_rst[%0d].busy", i), 32'(busy), 32'd0);
    end
    start = 1'b1; dir = 1'b1; limit = 4'd3;
    step();
    start = 1'b0;
    chk("post_rst_start_gray", 32'(gray), 32'd0);
    chk("post_rst_start_valid", 32'(out_valid), 32'd1);
    step();
    chk("post_rst_next_gray", 32'(gray), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
